// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the single byte-wide RAM port.
// Instruction fetch and the LSU each own one pending slot; accesses of
// 1/2/4 bytes are split into per-byte RAM cycles and assembled little-endian.
module mem_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instEn,
  input  logic [ADDR_W-1:0]     instAddr,
  input  logic                  instDiscard,
  output logic                  memInstOutEn,
  output logic [31:0]           memInst,
  input  logic                  dataEn,
  input  logic                  dataWr,
  input  logic [ADDR_W-1:0]     dataAddr,
  input  logic [1:0]            dataLen,
  input  logic [31:0]           dataIn,
  output logic                  dataOutEn,
  output logic [31:0]           dataOut,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr
);

  typedef enum logic [1:0] {IDLE, INST, DREAD, DWRITE} state_t;

  state_t                state_q;
  logic                  instPend_q;
  logic [ADDR_W-1:0]     instAddr_q;
  logic                  dataPend_q;
  logic                  dataWr_q;
  logic [ADDR_W-1:0]     dataAddr_q;
  logic [1:0]            dataLen_q;
  logic [31:0]           dataIn_q;
  logic [ADDR_W-1:0]     base_q;
  logic [31:0]           wrData_q;
  logic [2:0]            cnt_q;
  logic [2:0]            last_q;
  logic [31:0]           asm_q;
  logic [RAM_ADDR_W-1:0] ramA_q;
  logic [7:0]            ramDout_q;
  logic                  ramWr_q;
  logic [31:0]           memInst_q;
  logic [31:0]           dataOut_q;
  logic                  memInstOutEn_q;
  logic                  dataOutEn_q;

  logic                  instPend_d;
  logic [ADDR_W-1:0]     instAddr_d;
  logic                  dataPend_d;
  logic                  dataWr_d;
  logic [ADDR_W-1:0]     dataAddr_d;
  logic [1:0]            dataLen_d;
  logic [31:0]           dataIn_d;
  logic [2:0]            dataLast;
  logic [2:0]            cntInc;
  logic [ADDR_W-1:0]     nextAddr;
  logic [1:0]            byteIdx;
  logic [31:0]           asmNext;
  logic [7:0]            wrByte;
  logic                  readDone;
  logic                  writeDone;
  logic                  slotFree;
  logic                  unusedAddrHi;

  // Pending slots as they stand after this edge's requests, so a pulse can start the same edge it is seen
  always_comb begin
    instPend_d = instEn | (instPend_q & ~instDiscard);
    instAddr_d = instEn ? instAddr : instAddr_q;
    dataPend_d = dataEn | dataPend_q;
    dataWr_d   = dataEn ? dataWr : dataWr_q;
    dataAddr_d = dataEn ? dataAddr : dataAddr_q;
    dataLen_d  = dataEn ? dataLen : dataLen_q;
    dataIn_d   = dataEn ? dataIn : dataIn_q;
    case (dataLen_d)
      2'd0:    dataLast = 3'd1;
      2'd1:    dataLast = 3'd2;
      default: dataLast = 3'd4;
    endcase
  end

  // Byte-cycle helpers: next address, byte placement, store byte and end-of-access detection
  always_comb begin
    cntInc   = cnt_q + 3'd1;
    nextAddr = base_q + {{(ADDR_W-3){1'b0}}, cntInc};
    byteIdx  = cnt_q[1:0] - 2'd1;
    asmNext  = asm_q | ({24'd0, ram_din} << {byteIdx, 3'b000});
    case (cntInc[1:0])
      2'd1:    wrByte = wrData_q[15:8];
      2'd2:    wrByte = wrData_q[23:16];
      2'd3:    wrByte = wrData_q[31:24];
      default: wrByte = wrData_q[7:0];
    endcase
    readDone  = (((state_q == INST) && !instDiscard) || (state_q == DREAD)) && (cnt_q == last_q);
    writeDone = (state_q == DWRITE) && (cntInc == last_q);
    slotFree  = (state_q == IDLE) || readDone || writeDone;
  end

  assign unusedAddrHi = ^nextAddr[ADDR_W-1:RAM_ADDR_W];

  // Sequencer: steps the current access one byte per cycle and, when the port frees up, launches the next request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      instPend_q     <= 1'b0;
      instAddr_q     <= '0;
      dataPend_q     <= 1'b0;
      dataWr_q       <= 1'b0;
      dataAddr_q     <= '0;
      dataLen_q      <= 2'd0;
      dataIn_q       <= '0;
      base_q         <= '0;
      wrData_q       <= '0;
      cnt_q          <= 3'd0;
      last_q         <= 3'd0;
      asm_q          <= '0;
      ramA_q         <= '0;
      ramDout_q      <= 8'd0;
      ramWr_q        <= 1'b0;
      memInst_q      <= '0;
      dataOut_q      <= '0;
      memInstOutEn_q <= 1'b0;
      dataOutEn_q    <= 1'b0;
    end else begin
      memInstOutEn_q <= 1'b0;
      dataOutEn_q    <= 1'b0;
      instPend_q     <= instPend_d;
      instAddr_q     <= instAddr_d;
      dataPend_q     <= dataPend_d;
      dataWr_q       <= dataWr_d;
      dataAddr_q     <= dataAddr_d;
      dataLen_q      <= dataLen_d;
      dataIn_q       <= dataIn_d;

      case (state_q)
        INST, DREAD: begin
          if ((state_q == INST) && instDiscard) begin
            state_q <= IDLE;
            ramA_q  <= '0;
          end else if (cnt_q == last_q) begin
            if (state_q == INST) begin
              memInst_q      <= asmNext;
              memInstOutEn_q <= 1'b1;
            end else begin
              dataOut_q   <= asmNext;
              dataOutEn_q <= 1'b1;
            end
            state_q <= IDLE;
            ramA_q  <= '0;
          end else begin
            if (cnt_q != 3'd0) begin
              asm_q <= asmNext;
            end
            cnt_q  <= cntInc;
            ramA_q <= (cntInc == last_q) ? '0 : nextAddr[RAM_ADDR_W-1:0];
          end
        end
        DWRITE: begin
          if (writeDone) begin
            dataOut_q   <= '0;
            dataOutEn_q <= 1'b1;
            state_q     <= IDLE;
            ramA_q      <= '0;
            ramWr_q     <= 1'b0;
            ramDout_q   <= 8'd0;
          end else begin
            cnt_q     <= cntInc;
            ramA_q    <= nextAddr[RAM_ADDR_W-1:0];
            ramDout_q <= wrByte;
          end
        end
        default: begin
          ramA_q  <= '0;
          ramWr_q <= 1'b0;
        end
      endcase

      if (slotFree) begin
        if (dataPend_d) begin
          dataPend_q <= 1'b0;
          state_q    <= dataWr_d ? DWRITE : DREAD;
          base_q     <= dataAddr_d;
          wrData_q   <= dataIn_d;
          last_q     <= dataLast;
          cnt_q      <= 3'd0;
          asm_q      <= '0;
          ramA_q     <= dataAddr_d[RAM_ADDR_W-1:0];
          ramWr_q    <= dataWr_d;
          ramDout_q  <= dataWr_d ? dataIn_d[7:0] : 8'd0;
        end else if (instPend_d) begin
          instPend_q <= 1'b0;
          state_q    <= INST;
          base_q     <= instAddr_d;
          last_q     <= 3'd4;
          cnt_q      <= 3'd0;
          asm_q      <= '0;
          ramA_q     <= instAddr_d[RAM_ADDR_W-1:0];
          ramWr_q    <= 1'b0;
          ramDout_q  <= 8'd0;
        end
      end
    end
  end

  assign memInstOutEn = memInstOutEn_q & ~instDiscard;
  assign memInst      = memInst_q;
  assign dataOutEn    = dataOutEn_q;
  assign dataOut      = dataOut_q;
  assign ram_a        = ramA_q;
  assign ram_dout     = ramDout_q;
  assign ram_wr       = ramWr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: cycle-table bench for mem_ctrl. Each scenario fills a per-cycle
// table of input drives and expected outputs from the access timing rules,
// backed by a byte-array image of the RAM contents.
module tb_mem_ctrl;
  localparam int ADDR_W     = 32;
  localparam int RAM_ADDR_W = 17;
  localparam int RAM_SIZE   = 1 << RAM_ADDR_W;
  localparam int MAX_CYC    = 40;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  instEn;
  logic [ADDR_W-1:0]     instAddr;
  logic                  instDiscard;
  logic                  memInstOutEn;
  logic [31:0]           memInst;
  logic                  dataEn;
  logic                  dataWr;
  logic [ADDR_W-1:0]     dataAddr;
  logic [1:0]            dataLen;
  logic [31:0]           dataIn;
  logic                  dataOutEn;
  logic [31:0]           dataOut;
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;
  logic [RAM_ADDR_W-1:0] ram_a;
  logic                  ram_wr;

  mem_ctrl #(.ADDR_W(ADDR_W), .RAM_ADDR_W(RAM_ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .instEn(instEn), .instAddr(instAddr), .instDiscard(instDiscard),
    .memInstOutEn(memInstOutEn), .memInst(memInst),
    .dataEn(dataEn), .dataWr(dataWr), .dataAddr(dataAddr), .dataLen(dataLen),
    .dataIn(dataIn), .dataOutEn(dataOutEn), .dataOut(dataOut),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Memory image; updated by the model whenever a store is expected
  logic [7:0] memImg [0:RAM_SIZE-1];

  // Synchronous RAM read: byte appears one cycle after its address
  always @(posedge clk) ram_din <= memImg[ram_a];

  typedef struct {
    bit          rst, instEn, instDiscard, dataEn, dataWr;
    logic [31:0] instAddr, dataAddr, dataIn;
    logic [1:0]  dataLen;
    bit          eRamWr, eInstEn, eDataEn, chkRamA, chkDout, chkInst, chkData;
    logic [31:0] eRamA, eDout, eInst, eData;
  } cyc_t;

  cyc_t        sc [MAX_CYC];
  string       scName;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] lastInst, lastData;
  bit          instKnown;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nBytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : ((len == 2'd1) ? 2 : 4);
  endfunction

  task automatic clearScenario(input string name);
    scName = name;
    for (int i = 0; i < MAX_CYC; i++) sc[i] = '{default: 0};
  endtask

  // Read of n bytes whose first address goes out in cycle a0; only the first 'issued' addresses are expected
  task automatic expectRead(input int a0, input logic [31:0] addr, input int n, input int issued,
                            input bit isInst, input bit done);
    logic [31:0] val;
    logic [31:0] ba;
    val = 32'd0;
    for (int k = 0; k < n; k++) begin
      ba  = addr + 32'(k);
      val = val | (32'(memImg[ba[RAM_ADDR_W-1:0]]) << (8 * k));
      if (k < issued) begin
        sc[a0+k].chkRamA = 1'b1;
        sc[a0+k].eRamA   = 32'(ba[RAM_ADDR_W-1:0]);
      end
    end
    if (done) begin
      if (isInst) begin
        sc[a0+n+1].eInstEn = 1'b1;
        sc[a0+n+1].chkInst = 1'b1;
        sc[a0+n+1].eInst   = val;
        lastInst  = val;
        instKnown = 1'b1;
      end else begin
        sc[a0+n+1].eDataEn = 1'b1;
        sc[a0+n+1].chkData = 1'b1;
        sc[a0+n+1].eData   = val;
        lastData = val;
      end
    end
  endtask

  // Store of n bytes starting in cycle a0; the first 'issued' bytes reach the RAM
  task automatic expectWrite(input int a0, input logic [31:0] addr, input int n, input logic [31:0] data,
                             input int issued, input bit done);
    logic [31:0] ba;
    logic [7:0]  b;
    for (int k = 0; k < issued; k++) begin
      ba = addr + 32'(k);
      b  = 8'(data >> (8 * k));
      sc[a0+k].chkRamA = 1'b1;
      sc[a0+k].eRamA   = 32'(ba[RAM_ADDR_W-1:0]);
      sc[a0+k].eRamWr  = 1'b1;
      sc[a0+k].chkDout = 1'b1;
      sc[a0+k].eDout   = 32'(b);
      memImg[ba[RAM_ADDR_W-1:0]] = b;
    end
    if (done) begin
      sc[a0+n].eDataEn = 1'b1;
      sc[a0+n].chkData = 1'b1;
      sc[a0+n].eData   = 32'd0;
      lastData = 32'd0;
    end
  endtask

  task automatic expectIdle(input int c);
    sc[c].chkRamA = 1'b1;
    sc[c].eRamA   = 32'd0;
    sc[c].chkData = 1'b1;
    sc[c].eData   = lastData;
    if (instKnown) begin
      sc[c].chkInst = 1'b1;
      sc[c].eInst   = lastInst;
    end
  endtask

  task automatic checkCycle(input int c);
    string p;
    p = $sformatf("%s c%0d", scName, c);
    checkOutput({p, " ram_wr"}, 32'(ram_wr), 32'(sc[c].eRamWr));
    checkOutput({p, " memInstOutEn"}, 32'(memInstOutEn), 32'(sc[c].eInstEn));
    checkOutput({p, " dataOutEn"}, 32'(dataOutEn), 32'(sc[c].eDataEn));
    if (sc[c].chkRamA) checkOutput({p, " ram_a"}, 32'(ram_a), sc[c].eRamA);
    if (sc[c].chkDout) checkOutput({p, " ram_dout"}, 32'(ram_dout), sc[c].eDout);
    if (sc[c].chkInst) checkOutput({p, " memInst"}, memInst, sc[c].eInst);
    if (sc[c].chkData) checkOutput({p, " dataOut"}, dataOut, sc[c].eData);
  endtask

  // Plays the scenario table: drive inputs just after the edge, sample a unit later
  task automatic applyStimulus(input int len);
    for (int c = 0; c < len; c++) begin
      rst         = sc[c].rst;
      instEn      = sc[c].instEn;
      instAddr    = sc[c].instAddr;
      instDiscard = sc[c].instDiscard;
      dataEn      = sc[c].dataEn;
      dataWr      = sc[c].dataWr;
      dataAddr    = sc[c].dataAddr;
      dataLen     = sc[c].dataLen;
      dataIn      = sc[c].dataIn;
      #1;
      checkCycle(c);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; instEn = 1'b0; instDiscard = 1'b0; dataEn = 1'b0; dataWr = 1'b0;
  endtask

  task automatic runReset();
    clearScenario("reset");
    sc[0].rst = 1'b1;
    lastInst = 32'd0; lastData = 32'd0; instKnown = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sc[c].chkDout = 1'b1;
      sc[c].eDout   = 32'd0;
      expectIdle(c);
    end
    applyStimulus(2);
  endtask

  task automatic runLoad(input logic [31:0] addr, input logic [1:0] len);
    int n;
    clearScenario($sformatf("load@%08h/%0d", addr, len));
    n = nBytes(len);
    sc[1].dataEn = 1'b1; sc[1].dataAddr = addr; sc[1].dataLen = len; sc[1].dataIn = $urandom;
    expectRead(2, addr, n, n, 1'b0, 1'b1);
    expectIdle(n + 4);
    applyStimulus(n + 5);
  endtask

  task automatic runStore(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
    int n;
    clearScenario($sformatf("store@%08h/%0d", addr, len));
    n = nBytes(len);
    sc[1].dataEn = 1'b1; sc[1].dataWr = 1'b1; sc[1].dataAddr = addr; sc[1].dataLen = len; sc[1].dataIn = data;
    expectWrite(2, addr, n, data, n, 1'b1);
    expectIdle(n + 3);
    applyStimulus(n + 4);
  endtask

  task automatic runFetch(input logic [31:0] addr);
    clearScenario($sformatf("fetch@%08h", addr));
    sc[1].instEn = 1'b1; sc[1].instAddr = addr;
    expectRead(2, addr, 4, 4, 1'b1, 1'b1);
    expectIdle(8);
    applyStimulus(9);
  endtask

  task automatic runBoth(input logic [31:0] faddr, input logic [31:0] daddr, input logic [1:0] len);
    int n, f0;
    clearScenario($sformatf("both f%08h d%08h/%0d", faddr, daddr, len));
    n = nBytes(len);
    sc[1].instEn = 1'b1; sc[1].instAddr = faddr;
    sc[1].dataEn = 1'b1; sc[1].dataAddr = daddr; sc[1].dataLen = len;
    expectRead(2, daddr, n, n, 1'b0, 1'b1);
    f0 = 2 + n + 1;
    expectRead(f0, faddr, 4, 4, 1'b1, 1'b1);
    expectIdle(f0 + 6);
    applyStimulus(f0 + 7);
  endtask

  task automatic runDiscard(input logic [31:0] faddr, input int k, input bit withNew, input logic [31:0] naddr);
    clearScenario($sformatf("discard k%0d new%0d", k, withNew));
    sc[1].instEn = 1'b1; sc[1].instAddr = faddr;
    expectRead(2, faddr, 4, (k < 4) ? k + 1 : 4, 1'b1, 1'b0);
    sc[2+k].instDiscard = 1'b1;
    sc[3+k].chkRamA = 1'b1;
    sc[3+k].eRamA   = 32'd0;
    if (withNew) begin
      sc[2+k].instEn = 1'b1; sc[2+k].instAddr = naddr;
      expectRead(4 + k, naddr, 4, 4, 1'b1, 1'b1);
      expectIdle(10 + k);
      applyStimulus(11 + k);
    end else begin
      expectIdle(4 + k);
      applyStimulus(5 + k);
    end
  endtask

  task automatic runDiscardAtDone(input logic [31:0] addr);
    clearScenario("discard at done");
    sc[1].instEn = 1'b1; sc[1].instAddr = addr;
    expectRead(2, addr, 4, 4, 1'b1, 1'b0);
    sc[7].instDiscard = 1'b1;
    instKnown = 1'b0;
    expectIdle(8);
    applyStimulus(9);
  endtask

  task automatic runResetWrite(input logic [31:0] addr, input logic [31:0] data);
    clearScenario("reset mid-write");
    sc[1].dataEn = 1'b1; sc[1].dataWr = 1'b1; sc[1].dataAddr = addr; sc[1].dataLen = 2'd3; sc[1].dataIn = data;
    expectWrite(2, addr, 4, data, 2, 1'b0);
    sc[3].rst = 1'b1;
    lastInst = 32'd0; lastData = 32'd0; instKnown = 1'b1;
    sc[4].chkDout = 1'b1;
    sc[4].eDout   = 32'd0;
    expectIdle(4);
    expectIdle(5);
    applyStimulus(6);
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
    else if ($urandom_range(0, 5) == 0) a = 32'h0001_FFFF - 32'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    rst = 1'b1; instEn = 1'b0; instAddr = '0; instDiscard = 1'b0;
    dataEn = 1'b0; dataWr = 1'b0; dataAddr = '0; dataLen = 2'd0; dataIn = '0;
    for (int i = 0; i < RAM_SIZE; i++) memImg[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;

    runReset();
    runStore(32'h100, 2'd3, 32'h0000_0513);
    runFetch(32'h100);
    runStore(32'h200, 2'd3, 32'hDEAD_BEEF);
    runLoad(32'h200, 2'd3);
    runBoth(32'h300, 32'h10, 2'd0);
    runDiscard(32'h380, 2, 1'b1, 32'h400);
    runDiscardAtDone(32'h500);
    runResetWrite(32'h600, 32'hCAFE_F00D);
    runLoad(32'h600, 2'd3);
    runLoad(32'h1FFFF, 2'd1);
    runLoad(32'h41, 2'd2);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: runLoad(randAddr(), 2'($urandom_range(0, 3)));
        1: runStore(randAddr(), 2'($urandom_range(0, 3)), $urandom);
        2: runFetch(randAddr());
        3: runBoth(randAddr(), randAddr(), 2'($urandom_range(0, 3)));
        default: runDiscard(randAddr(), $urandom_range(0, 4), 1'($urandom_range(0, 1)), randAddr());
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
